ofifo_drain_arbiter: RTL and testbench

- Round-robin scheduler that drains num_fifo column output FIFOs (fifo_depth128 instances) into one shared SRAM write port.
- Grants one non-empty FIFO at a time and issues a burst of up to `burst` read pulses to it.
- Each popped word goes to the SRAM one cycle after the pop, at an address in that FIFO's private region.
- Sits between the array's output FIFO bank and the psum SRAM, in the single-clock core domain.

---
 rtl/ofifo_drain_arbiter_pkg.sv | 19 +
 rtl/ofifo_drain_arbiter_rr_arbiter.sv | 36 +++
 rtl/ofifo_drain_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ofifo_drain_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofifo_drain_arbiter_pkg.sv
// Shared definitions for the output-FIFO drain arbiter.
// Holds the default word-geometry constants and the FSM state encoding
// used by the top module.
package ofifo_drain_arbiter_pkg;

  // Default FIFO word geometry (lanes x bits per lane).
  localparam int SIMD_DEF     = 1;
  localparam int BW_DEF       = 4;
  localparam int FIFO_DATA_BW = SIMD_DEF * BW_DEF;

  // Burst counter width; covers burst lengths 1..16.
  localparam int CNT_BW = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/ofifo_drain_arbiter_rr_arbiter.sv
// Rotating-priority picker.
// Returns the first set bit of req found scanning base, base+1, ... (mod n).
// Ports:
//   req  - request vector, one bit per requester
//   base - index with highest priority this cycle
//   any  - at least one request is set
//   idx  - selected requester (equals base when nothing is requested)
module rr_arbiter #(
  parameter int n  = 8,
  parameter int iw = 3
) (
  input  logic [n-1:0]  req,
  input  logic [iw-1:0] base,
  output logic          any,
  output logic [iw-1:0] idx
);

  logic [iw-1:0] cand_s;

  // Scan from the farthest offset down to offset 0 so the nearest hit wins.
  // n is a power of two, so the iw-bit add wraps modulo n on its own.
  always_comb begin
    idx    = base;
    cand_s = base;
    for (int i = n - 1; i >= 0; i--) begin
      cand_s = base + iw'(i);
      if (req[cand_s]) begin
        idx = cand_s;
      end else begin
        idx = idx;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/ofifo_drain_arbiter.sv
// Round-robin drain of num_fifo column output FIFOs into one SRAM write port.
// A non-empty FIFO is granted, up to `burst` words are popped from it, and
// each word is written one cycle after its pop into that FIFO's private
// SRAM region at {fifo index, region pointer}.
// Ports:
//   clk, reset     - core clock, asynchronous active-low reset
//   en             - allows new grants (a running burst always completes)
//   clr_ptr        - clears region pointers and overflow flags (IDLE only)
//   fifo_empty     - per-FIFO empty flags
//   fifo_dout      - concatenated FIFO heads, FIFO i at [i*simd*bw +: simd*bw]
//   fifo_rd        - one-hot (or zero) read strobe, combinational
//   sram_wr/addr/d - registered SRAM write port
//   grant_idx      - current or last granted FIFO
//   busy           - burst in progress or write pending
//   overflow       - sticky per-region full flags
module ofifo_drain_arbiter
  import ofifo_drain_arbiter_pkg::*;
#(
  parameter int num_fifo  = 8,
  parameter int idx_bw    = 3,
  parameter int bw        = BW_DEF,
  parameter int simd      = SIMD_DEF,
  parameter int burst     = 4,
  parameter int region_bw = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          clr_ptr,
  input  logic [num_fifo-1:0]           fifo_empty,
  input  logic [num_fifo*simd*bw-1:0]   fifo_dout,
  output logic [num_fifo-1:0]           fifo_rd,
  output logic                          sram_wr,
  output logic [idx_bw+region_bw-1:0]   sram_addr,
  output logic [simd*bw-1:0]            sram_d,
  output logic [idx_bw-1:0]             grant_idx,
  output logic                          busy,
  output logic [num_fifo-1:0]           overflow
);

  localparam int DW = simd * bw;
  localparam logic [CNT_BW-1:0] BURST_LEN = CNT_BW'(burst);

  state_t                       state_r, state_nxt_s;
  logic [idx_bw-1:0]            rr_ptr_r, rr_ptr_nxt_s;
  logic [idx_bw-1:0]            grant_r, grant_nxt_s;
  logic [CNT_BW-1:0]            count_r, count_nxt_s;
  logic [region_bw-1:0]         ptr_r     [num_fifo];
  logic [region_bw-1:0]         ptr_nxt_s [num_fifo];
  logic [num_fifo-1:0]          overflow_r, overflow_nxt_s;
  logic                         sram_wr_r, sram_wr_nxt_s;
  logic [idx_bw+region_bw-1:0]  sram_addr_r, sram_addr_nxt_s;
  logic [DW-1:0]                sram_d_r, sram_d_nxt_s;

  logic [num_fifo-1:0]          elig_s;
  logic                         pick_any_s;
  logic [idx_bw-1:0]            pick_idx_s;
  logic                         pop_s;
  logic [region_bw-1:0]         cur_ptr_s;
  logic [DW-1:0]                cur_dout_s;
  logic [num_fifo-1:0]          rd_s;

  assign elig_s     = ~fifo_empty & ~overflow_r;
  assign cur_ptr_s  = ptr_r[grant_r];
  assign cur_dout_s = fifo_dout[grant_r*DW +: DW];
  assign pop_s      = (state_r == ST_BURST) & elig_s[grant_r];

  rr_arbiter #(
    .n  (num_fifo),
    .iw (idx_bw)
  ) u_rr (
    .req  (elig_s),
    .base (rr_ptr_r),
    .any  (pick_any_s),
    .idx  (pick_idx_s)
  );

  // Next-state, pointer-bank and SRAM-port computation.
  always_comb begin
    state_nxt_s     = state_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    grant_nxt_s     = grant_r;
    count_nxt_s     = count_r;
    ptr_nxt_s       = ptr_r;
    overflow_nxt_s  = overflow_r;
    sram_wr_nxt_s   = 1'b0;
    sram_addr_nxt_s = sram_addr_r;
    sram_d_nxt_s    = sram_d_r;
    rd_s            = '0;
    case (state_r)
      ST_IDLE: begin
        if (clr_ptr) begin
          for (int i = 0; i < num_fifo; i++) begin
            ptr_nxt_s[i] = '0;
          end
          overflow_nxt_s = '0;
        end else if (en && pick_any_s) begin
          grant_nxt_s = pick_idx_s;
          count_nxt_s = '0;
          state_nxt_s = ST_BURST;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (pop_s) begin
          rd_s[grant_r]      = 1'b1;
          sram_d_nxt_s       = cur_dout_s;
          sram_addr_nxt_s    = {grant_r, cur_ptr_s};
          sram_wr_nxt_s      = 1'b1;
          ptr_nxt_s[grant_r] = cur_ptr_s + {{(region_bw-1){1'b0}}, 1'b1};
          count_nxt_s        = count_r + {{(CNT_BW-1){1'b0}}, 1'b1};
          // Writing the last slot of the region makes it full; the pointer
          // wraps but the FIFO is not popped again until cleared.
          if (&cur_ptr_s) begin
            overflow_nxt_s[grant_r] = 1'b1;
          end else begin
            overflow_nxt_s[grant_r] = overflow_r[grant_r];
          end
        end else begin
          sram_wr_nxt_s = 1'b0;
        end
        // overflow_nxt_s covers both an already-full and a just-filled region.
        if ((pop_s && (count_nxt_s == BURST_LEN)) ||
            fifo_empty[grant_r] || overflow_nxt_s[grant_r]) begin
          state_nxt_s  = ST_IDLE;
          rr_ptr_nxt_s = grant_r + {{(idx_bw-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, pointer bank and registered SRAM port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      grant_r     <= '0;
      count_r     <= '0;
      for (int i = 0; i < num_fifo; i++) begin
        ptr_r[i] <= '0;
      end
      overflow_r  <= '0;
      sram_wr_r   <= 1'b0;
      sram_addr_r <= '0;
      sram_d_r    <= '0;
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      grant_r     <= grant_nxt_s;
      count_r     <= count_nxt_s;
      ptr_r       <= ptr_nxt_s;
      overflow_r  <= overflow_nxt_s;
      sram_wr_r   <= sram_wr_nxt_s;
      sram_addr_r <= sram_addr_nxt_s;
      sram_d_r    <= sram_d_nxt_s;
    end
  end

  assign fifo_rd   = rd_s;
  assign sram_wr   = sram_wr_r;
  assign sram_addr = sram_addr_r;
  assign sram_d    = sram_d_r;
  assign grant_idx = grant_r;
  assign overflow  = overflow_r;
  assign busy      = (state_r == ST_BURST) | sram_wr_r;

endmodule

// File: tb/tb_ofifo_drain_arbiter.sv
// Directed testbench for ofifo_drain_arbiter.
// dut uses region_bw=8; dut_b uses region_bw=2 for the region-overflow case.
// FIFOs are modelled as simple arrays with read/write counters.
module tb_ofifo_drain_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, clr_ptr, en_b, clr_b;
  logic [7:0]  fifo_empty, fifo_rd, ovf;
  logic [31:0] fifo_dout;
  logic        sram_wr, busy;
  logic [10:0] sram_addr;
  logic [3:0]  sram_d;
  logic [2:0]  gidx;

  logic [7:0]  b_empty, b_rd, b_ovf;
  logic [31:0] b_dout;
  logic        b_wr, b_busy;
  logic [4:0]  b_addr;
  logic [3:0]  b_d;
  logic [2:0]  b_gidx;

  ofifo_drain_arbiter #(.region_bw(8)) dut (
    .clk(clk), .reset(reset), .en(en), .clr_ptr(clr_ptr),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
    .sram_wr(sram_wr), .sram_addr(sram_addr), .sram_d(sram_d),
    .grant_idx(gidx), .busy(busy), .overflow(ovf)
  );

  ofifo_drain_arbiter #(.region_bw(2)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .clr_ptr(clr_b),
    .fifo_empty(b_empty), .fifo_dout(b_dout), .fifo_rd(b_rd),
    .sram_wr(b_wr), .sram_addr(b_addr), .sram_d(b_d),
    .grant_idx(b_gidx), .busy(b_busy), .overflow(b_ovf)
  );

  // FIFO bank model for dut
  logic [3:0] mem [8][32];
  int wp [8];
  int rp [8];
  int pops [8];

  for (genvar g = 0; g < 8; g++) begin : g_fifo
    assign fifo_empty[g]       = (wp[g] == rp[g]);
    assign fifo_dout[g*4 +: 4] = mem[g][rp[g][4:0]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (fifo_rd[i]) begin
        rp[i]   <= rp[i] + 1;
        pops[i] <= pops[i] + 1;
      end
    end
  end

  // Single FIFO (index 4) model for dut_b
  logic [3:0] bmem [8];
  int bwp, brp;
  assign b_empty = {3'b111, (bwp == brp), 4'b1111};
  assign b_dout  = {12'h000, bmem[brp[2:0]], 16'h0000};

  always @(posedge clk) begin
    if (b_rd[4]) brp <= brp + 1;
  end

  // SRAM write logs
  logic [10:0] log_a [64];
  logic [3:0]  log_d [64];
  int n_log;
  logic [4:0]  blog_a [8];
  logic [3:0]  blog_d [8];
  int n_blog;

  always @(posedge clk) begin
    if (sram_wr) begin
      log_a[n_log[5:0]] <= sram_addr;
      log_d[n_log[5:0]] <= sram_d;
      n_log <= n_log + 1;
    end
    if (b_wr) begin
      blog_a[n_blog[2:0]] <= b_addr;
      blog_d[n_blog[2:0]] <= b_d;
      n_blog <= n_blog + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int f, input logic [3:0] d);
    mem[f][wp[f][4:0]] = d;
    wp[f] = wp[f] + 1;
  endtask

  task automatic bpush(input logic [3:0] d);
    bmem[bwp[2:0]] = d;
    bwp = bwp + 1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Burst-limit cycle table: one entry per cycle after the grant edge
  int t_rd   [9] = '{1, 1, 1, 1, 0, 1, 1, 0, 0};
  int t_wr   [9] = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
  int t_busy [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
  int t_a    [9] = '{0, 0, 1, 2, 3, 0, 4, 5, 0};
  int t_d    [9] = '{0, 1, 2, 3, 4, 0, 5, 6, 0};

  // Round-robin expected writes
  int rr_a [6] = '{32'h100, 32'h101, 32'h300, 32'h301, 32'h600, 32'h601};
  int rr_d [6] = '{7, 8, 9, 10, 11, 12};

  int base;
  int p5;

  initial begin
    reset = 1'b0; en = 1'b0; clr_ptr = 1'b0; en_b = 1'b0; clr_b = 1'b0;
    bwp = 0;
    run(2);
    chk("rst_sram_wr", 32'(sram_wr), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_d", 32'(sram_d), 32'd0);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(gidx), 32'd0);
    chk("rst_overflow", 32'(ovf), 32'd0);
    chk("rst_b_overflow", 32'(b_ovf), 32'd0);
    reset = 1'b1;
    run(1);

    // Reset mid-burst on FIFO2
    for (int k = 1; k <= 10; k++) push(2, 4'(k));
    en = 1'b1;
    run(1);
    chk("mid_grant", 32'(gidx), 32'd2);
    chk("mid_rd1", 32'(fifo_rd), 32'h04);
    chk("mid_wr0", 32'(sram_wr), 32'd0);
    run(1);
    chk("mid_wr1", 32'(sram_wr), 32'd1);
    chk("mid_addr1", 32'(sram_addr), 32'h200);
    chk("mid_rd2", 32'(fifo_rd), 32'h04);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(sram_wr), 32'd0);
    chk("mid_rst_rd", 32'(fifo_rd), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(sram_addr), 32'd0);
    run(1);
    reset = 1'b1;
    base = n_log;
    run(20);
    chk("mid_nwrites", 32'(n_log - base), 32'd9);
    chk("mid_first_addr", 32'(log_a[base]), 32'h200);
    chk("mid_first_data", 32'(log_d[base]), 32'd2);
    chk("mid_last_addr", 32'(log_a[base + 8]), 32'h208);
    chk("mid_last_data", 32'(log_d[base + 8]), 32'd10);
    chk("mid_pops", 32'(pops[2]), 32'd10);
    en = 1'b0;
    run(2);

    // Burst limit on FIFO0 (6 words, burst 4)
    for (int k = 1; k <= 6; k++) push(0, 4'(k));
    en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      run(1);
      chk($sformatf("bl_rd_c%0d", c), 32'(fifo_rd), (t_rd[c] != 0) ? 32'h01 : 32'h00);
      chk($sformatf("bl_wr_c%0d", c), 32'(sram_wr), 32'(t_wr[c]));
      chk($sformatf("bl_busy_c%0d", c), 32'(busy), 32'(t_busy[c]));
      if (t_wr[c] != 0) begin
        chk($sformatf("bl_addr_c%0d", c), 32'(sram_addr), 32'(t_a[c]));
        chk($sformatf("bl_data_c%0d", c), 32'(sram_d), 32'(t_d[c]));
      end
    end
    en = 1'b0;
    run(2);

    // Round robin over FIFOs 1, 3, 6
    push(1, 4'd7);  push(1, 4'd8);
    push(3, 4'd9);  push(3, 4'd10);
    push(6, 4'd11); push(6, 4'd12);
    base = n_log;
    en = 1'b1;
    run(20);
    en = 1'b0;
    chk("rr_nwrites", 32'(n_log - base), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_addr%0d", k), 32'(log_a[base + k]), 32'(rr_a[k]));
      chk($sformatf("rr_data%0d", k), 32'(log_d[base + k]), 32'(rr_d[k]));
    end
    chk("rr_grant", 32'(gidx), 32'd6);
    run(2);

    // Early empty on FIFO5
    push(5, 4'd13); push(5, 4'd14);
    p5 = pops[5];
    base = n_log;
    en = 1'b1;
    run(8);
    en = 1'b0;
    chk("ee_pops", 32'(pops[5] - p5), 32'd2);
    chk("ee_nwrites", 32'(n_log - base), 32'd2);
    chk("ee_addr0", 32'(log_a[base]), 32'h500);
    chk("ee_addr1", 32'(log_a[base + 1]), 32'h501);
    chk("ee_data0", 32'(log_d[base]), 32'd13);
    chk("ee_data1", 32'(log_d[base + 1]), 32'd14);
    chk("ee_busy", 32'(busy), 32'd0);
    // rr_ptr now 6: FIFO6 beats FIFO5
    push(5, 4'd15); push(6, 4'd2);
    base = n_log;
    en = 1'b1;
    run(1);
    chk("ee_rr_grant", 32'(gidx), 32'd6);
    run(10);
    en = 1'b0;
    chk("ee_rr_nwrites", 32'(n_log - base), 32'd2);
    chk("ee_rr_addr0", 32'(log_a[base]), 32'h602);
    chk("ee_rr_data0", 32'(log_d[base]), 32'd2);
    chk("ee_rr_addr1", 32'(log_a[base + 1]), 32'h502);
    chk("ee_rr_data1", 32'(log_d[base + 1]), 32'd15);
    run(2);

    // en gating
    for (int f = 0; f < 8; f++) push(f, 4'(f));
    for (int c = 0; c < 5; c++) begin
      run(1);
      chk($sformatf("en0_rd_c%0d", c), 32'(fifo_rd), 32'd0);
      chk($sformatf("en0_busy_c%0d", c), 32'(busy), 32'd0);
    end
    base = n_log;
    en = 1'b1;
    run(1);
    chk("endrop_grant", 32'(gidx), 32'd6);
    chk("endrop_busy", 32'(busy), 32'd1);
    en = 1'b0;
    run(10);
    chk("endrop_nwrites", 32'(n_log - base), 32'd1);
    chk("endrop_addr", 32'(log_a[base]), 32'h603);
    chk("endrop_data", 32'(log_d[base]), 32'd6);
    chk("endrop_empty", 32'(fifo_empty), 32'h40);
    chk("endrop_busy_end", 32'(busy), 32'd0);

    // Region overflow on dut_b (region_bw=2)
    for (int k = 1; k <= 5; k++) bpush(4'(k));
    en_b = 1'b1;
    run(10);
    chk("ov_nwrites", 32'(n_blog), 32'd4);
    chk("ov_addr0", 32'(blog_a[0]), 32'h10);
    chk("ov_data0", 32'(blog_d[0]), 32'd1);
    chk("ov_addr3", 32'(blog_a[3]), 32'h13);
    chk("ov_data3", 32'(blog_d[3]), 32'd4);
    chk("ov_flag", 32'(b_ovf), 32'h10);
    chk("ov_left", 32'(bwp - brp), 32'd1);
    chk("ov_busy", 32'(b_busy), 32'd0);
    clr_b = 1'b1;
    run(1);
    clr_b = 1'b0;
    chk("ov_clr_flag", 32'(b_ovf), 32'd0);
    chk("ov_clr_nogrant", 32'(b_busy), 32'd0);
    run(6);
    en_b = 1'b0;
    chk("ov_nwrites2", 32'(n_blog), 32'd5);
    chk("ov_addr4", 32'(blog_a[4]), 32'h10);
    chk("ov_data4", 32'(blog_d[4]), 32'd5);
    chk("ov_left2", 32'(bwp - brp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
